i2s_audio_tx: RTL and testbench

//  Serialises the guest core's parallel stereo audio samples onto the board I2S pins (I2S_BCK/I2S_LRCK/I2S_DATA).

---
 rtl/audio_pkg.sv | 25 ++
 rtl/nco_tick.sv | 34 +++
 rtl/i2s_audio_tx.sv | 116 +++++++++++
 tb/tb_i2s_audio_tx.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio-output helpers.
//   I2S_SLOT_BITS / I2S_FRAME_BITS : bit clocks per channel slot / per stereo frame
//   nco_inc()          : phase-accumulator increment for a given output tick rate
//   to_offset_signed() : converts an MSB-justified sample to two's complement
package audio_pkg;

    localparam int unsigned I2S_SLOT_BITS  = 32;
    localparam int unsigned I2S_FRAME_BITS = 64;

    // Increment giving out_hz carries per second from a clk_hz accumulator of
    // acc_w bits, rounded to nearest.
    function automatic longint unsigned nco_inc(input longint unsigned clk_hz,
                                                input longint unsigned out_hz,
                                                input int unsigned     acc_w);
        return ((64'd1 << acc_w) * out_hz + clk_hz / 2) / clk_hz;
    endfunction

    // sample is MSB-justified in 32 bits, so the sign/offset bit is always
    // bit 31 whatever the source width.
    function automatic logic [31:0] to_offset_signed(input logic [31:0] sample,
                                                     input logic        signed_in);
        return signed_in ? sample : (sample ^ 32'h8000_0000);
    endfunction

endpackage

// File: rtl/nco_tick.sv
// Fractional phase accumulator producing a one-clock tick on each carry-out.
//   clk_sys : system clock
//   reset   : asynchronous, active-high reset (acc = 0)
//   clr     : synchronous clear (acc = 0, no tick)
//   tick    : carry-out of acc + INC in the current clock
module nco_tick #(
    parameter int unsigned      ACC_W = 32,
    parameter logic [ACC_W-1:0] INC   = '0
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    always_comb begin
        sum  = {1'b0, acc} + {1'b0, INC};
        tick = sum[ACC_W] & ~clr;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else begin
            acc <= sum[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/i2s_audio_tx.sv
// Philips I2S transmitter for the guest core's stereo samples.
//   clk_sys     : system clock
//   reset       : asynchronous, active-high reset
//   en          : 1 = run, 0 = idle with all outputs low
//   audio_l/r   : parallel samples, captured once per frame
//   sample_ack  : one-clock pulse in the cycle audio_l/r are captured
//   i2s_bck     : bit clock, 64 periods per frame
//   i2s_lrck    : word select, 0 = left, 1 = right
//   i2s_data    : serial data, MSB first, one bit clock after the LRCK edge
module i2s_audio_tx
    import audio_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned SAMPLE_HZ = 48_000,
    parameter int unsigned SAMPLE_W  = 16,
    parameter int unsigned SIGNED_IN = 0,
    parameter int unsigned ACC_W     = 32
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] audio_l,
    input  logic [SAMPLE_W-1:0] audio_r,
    output logic                sample_ack,
    output logic                i2s_bck,
    output logic                i2s_lrck,
    output logic                i2s_data
);

    // The accumulator ticks at twice the BCK rate: one tick per BCK edge.
    localparam longint unsigned INC_FULL =
        nco_inc(64'(CLK_HZ), 64'(2 * I2S_FRAME_BITS * SAMPLE_HZ), ACC_W);
    localparam logic [ACC_W-1:0] INC = INC_FULL[ACC_W-1:0];

    if (INC_FULL >= (64'd1 << (ACC_W - 1))) begin : g_rate_check
        $error("i2s_audio_tx: BCK rate exceeds CLK_HZ/4");
    end
    if (SAMPLE_W < 1 || SAMPLE_W > 31) begin : g_width_check
        $error("i2s_audio_tx: SAMPLE_W must be 1..31");
    end

    logic                tick;
    logic                nco_clr;
    logic [5:0]          bit_cnt;
    logic [5:0]          bit_cnt_nx;
    logic                falling;
    logic                wrap;
    logic [31:0]         conv_l;
    logic [31:0]         conv_r;
    logic [SAMPLE_W-1:0] smp_l;
    logic [SAMPLE_W-1:0] smp_r;
    logic [SAMPLE_W-1:0] smp_l_nx;
    logic [SAMPLE_W-1:0] smp_r_nx;
    logic [31:0]         slot;
    logic                data_nx;

    assign nco_clr = ~en;

    nco_tick #(
        .ACC_W (ACC_W),
        .INC   (INC)
    ) u_nco (
        .clk_sys (clk_sys),
        .reset   (reset),
        .clr     (nco_clr),
        .tick    (tick)
    );

    always_comb begin
        falling    = tick & i2s_bck;
        bit_cnt_nx = bit_cnt + 6'd1;
        wrap       = falling & (bit_cnt == 6'd63);

        conv_l   = to_offset_signed(32'(audio_l) << (32 - SAMPLE_W), SIGNED_IN != 0);
        conv_r   = to_offset_signed(32'(audio_r) << (32 - SAMPLE_W), SIGNED_IN != 0);
        smp_l_nx = wrap ? conv_l[31 -: SAMPLE_W] : smp_l;
        smp_r_nx = wrap ? conv_r[31 -: SAMPLE_W] : smp_r;

        // Place the sample so its MSB sits at bit 30: slot position p then maps
        // to bit 31-p, which yields 0 for p=0 and for every p past the LSB.
        slot    = 32'(bit_cnt_nx[5] ? smp_r_nx : smp_l_nx) << (31 - SAMPLE_W);
        data_nx = slot[~bit_cnt_nx[4:0]];
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            bit_cnt    <= 6'd63;
            i2s_bck    <= 1'b0;
            i2s_lrck   <= 1'b0;
            i2s_data   <= 1'b0;
            sample_ack <= 1'b0;
            smp_l      <= '0;
            smp_r      <= '0;
        end else if (!en) begin
            // Parking bit_cnt at 63 makes the first fall after enable a frame latch.
            bit_cnt    <= 6'd63;
            i2s_bck    <= 1'b0;
            i2s_lrck   <= 1'b0;
            i2s_data   <= 1'b0;
            sample_ack <= 1'b0;
        end else begin
            sample_ack <= wrap;
            smp_l      <= smp_l_nx;
            smp_r      <= smp_r_nx;
            if (tick) begin
                i2s_bck <= ~i2s_bck;
            end
            if (falling) begin
                bit_cnt  <= bit_cnt_nx;
                i2s_lrck <= bit_cnt_nx[5];
                i2s_data <= data_nx;
            end
        end
    end

endmodule

// File: tb/tb_i2s_audio_tx.sv
`timescale 1ns/1ps
module tb_i2s_audio_tx;

    localparam int unsigned TB_CLK_HZ    = 1_000_000;
    localparam int unsigned TB_SAMPLE_HZ = 3_000;
    localparam int          RATE_CLKS    = 20_000;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] audio_l;
    logic [15:0] audio_r;
    logic [1:0]  ack_w;
    logic [1:0]  bck_w;
    logic [1:0]  lrck_w;
    logic [1:0]  data_w;

    int n_assert;
    int n_fail;

    // index 0: two's complement inputs, index 1: offset-binary inputs
    i2s_audio_tx #(
        .CLK_HZ    (TB_CLK_HZ),
        .SAMPLE_HZ (TB_SAMPLE_HZ),
        .SAMPLE_W  (16),
        .SIGNED_IN (1),
        .ACC_W     (32)
    ) dut_s (
        .clk_sys    (clk),
        .reset      (rst),
        .en         (en),
        .audio_l    (audio_l),
        .audio_r    (audio_r),
        .sample_ack (ack_w[0]),
        .i2s_bck    (bck_w[0]),
        .i2s_lrck   (lrck_w[0]),
        .i2s_data   (data_w[0])
    );

    i2s_audio_tx #(
        .CLK_HZ    (TB_CLK_HZ),
        .SAMPLE_HZ (TB_SAMPLE_HZ),
        .SAMPLE_W  (16),
        .SIGNED_IN (0),
        .ACC_W     (32)
    ) dut_u (
        .clk_sys    (clk),
        .reset      (rst),
        .en         (en),
        .audio_l    (audio_l),
        .audio_r    (audio_r),
        .sample_ack (ack_w[1]),
        .i2s_bck    (bck_w[1]),
        .i2s_lrck   (lrck_w[1]),
        .i2s_data   (data_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receiver model state: a frame is the 64 BCK rises following a sample_ack.
    logic [63:0] fr       [2];
    int          pos      [2];
    bit          sync     [2];
    bit          lrck_bad [2];
    logic [15:0] exp_l    [2];
    logic [15:0] exp_r    [2];
    logic [15:0] last_l   [2];
    logic [15:0] last_r   [2];
    logic        ack_prev [2];
    logic        bck_prev [2];
    logic        lrck_prev0;
    int          rise_cnt;
    int          fall_cnt;
    bit          meas;
    bit          phase_seen;
    int          phase_len;
    int          phase_min;
    int          phase_max;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic decode_frame(input int d);
        logic [15:0] l;
        logic [15:0] r;
        logic [63:0] pad_mask;
        l        = '0;
        r        = '0;
        pad_mask = '1;
        for (int i = 1; i <= 16; i++) begin
            l = {l[14:0], fr[d][i]};
            r = {r[14:0], fr[d][32 + i]};
            pad_mask[i]      = 1'b0;
            pad_mask[32 + i] = 1'b0;
        end
        check($sformatf("left_word[%0d]", d), 32'(l), 32'(exp_l[d]));
        check($sformatf("right_word[%0d]", d), 32'(r), 32'(exp_r[d]));
        check($sformatf("pad_bits[%0d]", d), 32'(|(fr[d] & pad_mask)), 32'd0);
        check($sformatf("lrck_pattern[%0d]", d), 32'(lrck_bad[d]), 32'd0);
        last_l[d] = l;
        last_r[d] = r;
    endtask

    task automatic monitor();
        phase_len++;
        if (bck_w[0] !== bck_prev[0]) begin
            if (bck_w[0] === 1'b1) rise_cnt++;
            if (meas) begin
                if (phase_seen) begin
                    if (phase_len < phase_min) phase_min = phase_len;
                    if (phase_len > phase_max) phase_max = phase_len;
                end
                phase_seen = 1'b1;
            end
            phase_len = 0;
        end
        if (lrck_prev0 === 1'b1 && lrck_w[0] === 1'b0) fall_cnt++;
        lrck_prev0 = lrck_w[0];

        for (int d = 0; d < 2; d++) begin
            if (rst || !en) begin
                sync[d] = 1'b0;
            end else begin
                if (ack_w[d] === 1'b1) begin
                    check($sformatf("ack_width[%0d]", d), 32'(ack_prev[d]), 32'd0);
                    if (sync[d]) check($sformatf("frame_len[%0d]", d), 32'(pos[d]), 32'd64);
                    // Offset-binary to two's complement is a shift by half range.
                    exp_l[d]    = (d == 0) ? audio_l : 16'(audio_l + 16'h8000);
                    exp_r[d]    = (d == 0) ? audio_r : 16'(audio_r + 16'h8000);
                    pos[d]      = 0;
                    fr[d]       = '0;
                    lrck_bad[d] = 1'b0;
                    sync[d]     = 1'b1;
                end
                if (bck_w[d] === 1'b1 && bck_prev[d] === 1'b0 && sync[d]) begin
                    if (pos[d] < 64) begin
                        fr[d][pos[d]] = data_w[d];
                        if (lrck_w[d] !== (pos[d] >= 32)) lrck_bad[d] = 1'b1;
                    end
                    pos[d]++;
                    if (pos[d] == 64) decode_frame(d);
                end
            end
            ack_prev[d] = ack_w[d];
            bck_prev[d] = bck_w[d];
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        #1;
    endtask

    initial begin
        int  r0;
        int  f0;
        int  dev;
        bit  found;
        n_assert   = 0;
        n_fail     = 0;
        rise_cnt   = 0;
        fall_cnt   = 0;
        meas       = 1'b0;
        phase_seen = 1'b0;
        phase_len  = 0;
        phase_min  = 1000;
        phase_max  = 0;
        lrck_prev0 = 1'b0;
        for (int d = 0; d < 2; d++) begin
            pos[d] = 0; sync[d] = 1'b0; lrck_bad[d] = 1'b0; fr[d] = '0;
            exp_l[d] = '0; exp_r[d] = '0; last_l[d] = '0; last_r[d] = '0;
            ack_prev[d] = 1'b0; bck_prev[d] = 1'b0;
        end

        // Reset state
        rst     = 1'b1;
        en      = 1'b1;
        audio_l = 16'hA55A;
        audio_r = 16'h1234;
        repeat (4) step();
        check("reset_outputs", 32'({bck_w, lrck_w, data_w, ack_w}), 32'd0);
        rst = 1'b0;

        // Fixed two's complement pattern
        repeat (1400) step();
        check("fixed_left", 32'(last_l[0]), 32'h0000_A55A);
        check("fixed_right", 32'(last_r[0]), 32'h0000_1234);

        // Inputs changing every clock; rate measured over the same window
        r0   = rise_cnt;
        f0   = fall_cnt;
        meas = 1'b1;
        for (int i = 0; i < RATE_CLKS; i++) begin
            step();
            audio_l = 16'($urandom);
            audio_r = 16'($urandom);
        end
        meas = 1'b0;
        dev = (rise_cnt - r0) - RATE_CLKS * 64 * int'(TB_SAMPLE_HZ / 1000) / int'(TB_CLK_HZ / 1000);
        check("bck_rate_dev", 32'((dev >= -1 && dev <= 1) ? 0 : dev), 32'd0);
        dev = (fall_cnt - f0) - RATE_CLKS * int'(TB_SAMPLE_HZ / 1000) / int'(TB_CLK_HZ / 1000);
        check("lrck_rate_dev", 32'((dev >= -1 && dev <= 1) ? 0 : dev), 32'd0);
        check("bck_phase_spread", 32'((phase_max - phase_min) <= 1), 32'd1);

        // Offset-binary extremes
        audio_l = 16'h0000;
        audio_r = 16'hFFFF;
        repeat (1100) step();
        check("unsigned_left", 32'(last_l[1]), 32'h0000_8000);
        check("unsigned_right", 32'(last_r[1]), 32'h0000_7FFF);

        // Disable in the middle of the right slot, then re-enable
        audio_l = 16'h0F0F;
        audio_r = 16'hF0F0;
        found = 1'b0;
        for (int i = 0; i < 800 && !found; i++) begin
            step();
            if (lrck_w[0] === 1'b1) found = 1'b1;
        end
        check("reach_right_slot", 32'(found), 32'd1);
        repeat (20) step();
        en = 1'b0;
        step();
        check("disable_outputs", 32'({bck_w, lrck_w, data_w, ack_w}), 32'd0);
        repeat (100) step();
        check("disabled_outputs_held", 32'({bck_w, lrck_w, data_w, ack_w}), 32'd0);
        en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (bck_prev[0] === 1'b0 && ack_w[0] === 1'b0 && i > 0 && lrck_w[0] === 1'b0
                && bck_w[0] === 1'b0 && data_w[0] === 1'b0) begin
                // nothing to see yet: idle or bck high phase
            end
            if (ack_w !== 2'b00) begin
                // the first ack must coincide with the first BCK fall after enable
                check("restart_ack_on_first_fall", 32'(rise_cnt > 0 && bck_w == 2'b00), 32'd1);
                check("restart_ack_both", 32'(ack_w), 32'd3);
                found = 1'b1;
            end
        end
        check("restart_ack_seen", 32'(found), 32'd1);
        repeat (700) step();
        check("restart_left", 32'(last_l[0]), 32'h0000_0F0F);
        check("restart_right", 32'(last_r[1]), 32'h0000_70F0);

        // Asynchronous reset between clock edges, mid-frame
        repeat (150) step();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", 32'({bck_w, lrck_w, data_w, ack_w}), 32'd0);
        repeat (5) step();
        check("reset_held_outputs", 32'({bck_w, lrck_w, data_w, ack_w}), 32'd0);
        audio_l = 16'hA55A;
        audio_r = 16'h1234;
        rst = 1'b0;
        repeat (1100) step();
        check("post_reset_left", 32'(last_l[0]), 32'h0000_A55A);
        check("post_reset_right", 32'(last_r[0]), 32'h0000_1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
